// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared definitions for the cluster APU arbiter.
//   - Default requester count and outstanding-request depth.
//   - ID width helper (clog2 with a floor of 1 bit).
//   - Lock state encoding used by the arbiter.
package cv32e40p_apu_core_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned APU_ARB_NUM_REQ         = 2;
  localparam int unsigned APU_ARB_MAX_OUTSTANDING = 2;
  localparam int unsigned APU_ARB_ID_W            = clog2_min1(APU_ARB_NUM_REQ);

  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } apu_arb_lock_e;

endpackage

// File: rtl/cv32e40p_apu_arb_fifo.sv
// In-order requester-ID FIFO for the APU arbiter.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  write an ID (accepted when not full, or when full and popping)
//   pop_i          drop the head entry (ignored when empty)
//   full_o/empty_o occupancy flags
//   head_o         oldest ID
//   count_o        occupancy, 0..DEPTH
module cv32e40p_apu_arb_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH  = APU_ARB_MAX_OUTSTANDING,
  parameter int unsigned DATA_W = APU_ARB_ID_W,
  localparam int unsigned PTR_W = clog2_min1(DEPTH),
  localparam int unsigned CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs when full.
    do_push  = push_i & (~full_o | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one APU among NUM_REQ per-core dispatchers.
// Picks a winner (round-robin, or fixed priority when
// CV32E40P_APU_ARB_FIXED_PRIO_EN is defined), forwards its payload, holds the
// selection while the APU stalls, records winner IDs in issue order and routes
// each in-order response back to its requester.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i, payload_i         per-requester request and payload
//   gnt_o, rvalid_o          per-requester grant / response valid (one-hot or 0)
//   result_o                 response data broadcast to all requesters
//   apu_req_o, apu_payload_o request and payload towards the APU
//   apu_gnt_i                APU accepts the request
//   apu_rvalid_i, apu_result_i  in-order APU response
//   busy_o                   at least one request outstanding
//   spurious_o               response arrived with nothing to route
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned NUM_REQ         = APU_ARB_NUM_REQ,
  parameter int unsigned PAYLOAD_W       = 128,
  parameter int unsigned RESULT_W        = 37,
  parameter int unsigned MAX_OUTSTANDING = APU_ARB_MAX_OUTSTANDING
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0]  payload_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [RESULT_W-1:0]                result_o,
  output logic                               apu_req_o,
  output logic [PAYLOAD_W-1:0]               apu_payload_o,
  input  logic                               apu_gnt_i,
  input  logic                               apu_rvalid_i,
  input  logic [RESULT_W-1:0]                apu_result_i,
  output logic                               busy_o,
  output logic                               spurious_o
);

  localparam int unsigned ID_W  = clog2_min1(NUM_REQ);
  localparam int unsigned CNT_W = clog2_min1(MAX_OUTSTANDING + 1);

  apu_arb_lock_e   lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_winner;
  logic            rr_found;
  int unsigned     rr_idx;
  logic [ID_W-1:0] rr_cand;
  logic [ID_W-1:0] winner;
  logic            win_valid;
  logic            credit_ok;
  logic            route_pop;
  logic            bypass;
  logic            hs;
  logic            push;
  logic            fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;

`ifdef CV32E40P_APU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`endif

  // First asserted request at or after rr_ptr, wrapping.
  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    rr_idx    = 0;
    rr_cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_idx  = (32'(rr_ptr) + i) % NUM_REQ;
      rr_cand = ID_W'(rr_idx);
      if (!rr_found && req_i[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // While locked the stalled requester keeps the APU port; if it withdraws,
  // nothing is offered this cycle and arbitration resumes on the next one.
  assign winner    = (lock_q == LOCK_HELD) ? lock_id_q : rr_winner;
  assign win_valid = (lock_q == LOCK_HELD) ? req_i[lock_id_q] : rr_found;

  assign route_pop  = apu_rvalid_i & ~fifo_empty;
  assign credit_ok  = ~fifo_full | route_pop;
  assign apu_req_o  = win_valid & credit_ok;
  assign hs         = apu_req_o & apu_gnt_i;
  // Single-cycle op with nothing in flight: answer goes straight to the winner.
  assign bypass     = apu_rvalid_i & fifo_empty & hs;
  assign push       = hs & ~bypass;
  assign spurious_o = apu_rvalid_i & fifo_empty & ~hs;
  assign busy_o     = (fifo_count != '0);

  assign apu_payload_o = win_valid ? payload_i[winner] : '0;
  assign result_o      = (route_pop | bypass) ? apu_result_i : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs) begin
      gnt_o[winner] = 1'b1;
    end
    if (route_pop) begin
      rvalid_o[fifo_head] = 1'b1;
    end else if (bypass) begin
      rvalid_o[winner] = 1'b1;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      lock_d = LOCK_FREE;
    end else if ((lock_q == LOCK_HELD) && !req_i[lock_id_q]) begin
      lock_d = LOCK_FREE;
    end else if (apu_req_o) begin
      lock_d    = LOCK_HELD;
      lock_id_d = winner;
    end
  end

`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= LOCK_FREE;
      lock_id_q <= '0;
`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  cv32e40p_apu_arb_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (winner),
    .pop_i   (route_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for cv32e40p_apu_arbiter (NUM_REQ=2, MAX_OUTSTANDING=2).
// Builds with or without CV32E40P_APU_ARB_FIXED_PRIO_EN.
module tb_cv32e40p_apu_arbiter;

  localparam logic [127:0] P0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] P1 = 128'hB1B1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;

  logic                  clk_i;
  logic                  rst_ni;
  logic [1:0]            req_i;
  logic [1:0][127:0]     payload_i;
  logic [1:0]            gnt_o;
  logic [1:0]            rvalid_o;
  logic [36:0]           result_o;
  logic                  apu_req_o;
  logic [127:0]          apu_payload_o;
  logic                  apu_gnt_i;
  logic                  apu_rvalid_i;
  logic [36:0]           apu_result_i;
  logic                  busy_o;
  logic                  spurious_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]   exp_g, exp_rv;
  logic [36:0]  exp_res;
  logic [127:0] exp_pl;

  cv32e40p_apu_arbiter #(
    .NUM_REQ         (2),
    .PAYLOAD_W       (128),
    .RESULT_W        (37),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .payload_i     (payload_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .result_o      (result_o),
    .apu_req_o     (apu_req_o),
    .apu_payload_o (apu_payload_o),
    .apu_gnt_i     (apu_gnt_i),
    .apu_rvalid_i  (apu_rvalid_i),
    .apu_result_i  (apu_result_i),
    .busy_o        (busy_o),
    .spurious_o    (spurious_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic [36:0] res);
    req_i        = r;
    apu_gnt_i    = g;
    apu_rvalid_i = rv;
    apu_result_i = res;
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    payload_i[0] = P0;
    payload_i[1] = P1;
    req_i        = '0;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    #12;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_apu_req", apu_req_o, 0);
    chk("rst_payload", apu_payload_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_spurious", spurious_o, 0);
    rst_ni = 1'b1;
    tick();

`ifndef CV32E40P_APU_ARB_FIXED_PRIO_EN
    // Both requesting, APU always accepts, responses 2 cycles after issue.
    for (int c = 0; c < 8; c++) begin
      drive((c < 6) ? 2'b11 : 2'b00, c < 6, c >= 2, 37'(c + 100));
      exp_g   = (c < 6) ? (((c % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv  = (c >= 2) ? (((c % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_res = (c >= 2) ? 37'(c + 100) : 37'd0;
      exp_pl  = (c < 6) ? (((c % 2) == 0) ? P0 : P1) : 128'd0;
      chk("rr_gnt", gnt_o, exp_g);
      chk("rr_rvalid", rvalid_o, exp_rv);
      chk("rr_result", result_o, exp_res);
      chk("rr_payload", apu_payload_o, exp_pl);
      chk("rr_busy", busy_o, (c == 0) ? 0 : 1);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("rr_drained", busy_o, 0);
`else
    // Fixed priority: requester 0 wins every time (single-cycle ops).
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 1'b1, 1'b1, 37'(c + 200));
      chk("fp_gnt", gnt_o, 2'b01);
      chk("fp_rvalid", rvalid_o, 2'b01);
      chk("fp_payload", apu_payload_o, P0);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("fp_busy", busy_o, 0);
`endif

    // Lock: requester 1 stalled 3 cycles, requester 0 joins in cycle 1.
    for (int c = 0; c < 4; c++) begin
      drive((c == 0) ? 2'b10 : 2'b11, c == 3, 1'b0, '0);
      chk("lock_payload", apu_payload_o, P1);
      chk("lock_apu_req", apu_req_o, 1);
      chk("lock_gnt", gnt_o, (c == 3) ? 2'b10 : 2'b00);
      tick();
    end
    drive(2'b00, 1'b0, 1'b1, 37'h1_2345_6789);
    chk("lock_rvalid", rvalid_o, 2'b10);
    chk("lock_result", result_o, 37'h1_2345_6789);
    chk("lock_spurious", spurious_o, 0);
    tick();

    // Single-cycle op with FIFO empty: bypass, no push.
    drive(2'b01, 1'b1, 1'b1, 37'h0_0000_0055);
    chk("byp_gnt", gnt_o, 2'b01);
    chk("byp_rvalid", rvalid_o, 2'b01);
    chk("byp_result", result_o, 37'h0_0000_0055);
    chk("byp_spurious", spurious_o, 0);
    tick();
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("byp_busy", busy_o, 0);

    // Locked requester withdraws; arbitration resumes next cycle.
    drive(2'b01, 1'b0, 1'b0, '0);
    chk("drop_apu_req", apu_req_o, 1);
    chk("drop_payload", apu_payload_o, P0);
    chk("drop_gnt0", gnt_o, 2'b00);
    tick();
    drive(2'b10, 1'b0, 1'b0, '0);
    chk("drop_gnt1", gnt_o, 2'b00);
    tick();
    drive(2'b10, 1'b1, 1'b0, '0);
    chk("drop_gnt2", gnt_o, 2'b10);
    chk("drop_payload2", apu_payload_o, P1);
    tick();
    drive(2'b00, 1'b0, 1'b1, 37'h7);
    chk("drop_rvalid", rvalid_o, 2'b10);
    tick();

    // Credit limit: fill to 2, stall, then pop-and-push in one cycle.
    drive(2'b01, 1'b1, 1'b0, '0);
    chk("full_gnt_a", gnt_o, 2'b01);
    tick();
    drive(2'b10, 1'b1, 1'b0, '0);
    chk("full_gnt_b", gnt_o, 2'b10);
    tick();
    drive(2'b11, 1'b1, 1'b0, '0);
    chk("full_apu_req", apu_req_o, 0);
    chk("full_gnt_blocked", gnt_o, 2'b00);
    chk("full_busy", busy_o, 1);
    tick();
    drive(2'b11, 1'b1, 1'b1, 37'h11);
    chk("swap_apu_req", apu_req_o, 1);
    chk("swap_gnt", gnt_o, 2'b01);
    chk("swap_rvalid", rvalid_o, 2'b01);
    tick();
    drive(2'b11, 1'b1, 1'b0, '0);
    chk("swap_still_full", apu_req_o, 0);
    chk("swap_gnt_blocked", gnt_o, 2'b00);
    tick();
    drive(2'b00, 1'b0, 1'b1, 37'h22);
    chk("full_drain_a", rvalid_o, 2'b10);
    tick();
    drive(2'b00, 1'b0, 1'b1, 37'h33);
    chk("full_drain_b", rvalid_o, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("full_busy_end", busy_o, 0);

    // Response with nothing outstanding.
    drive(2'b00, 1'b0, 1'b1, 37'h44);
    chk("spur_pulse", spurious_o, 1);
    chk("spur_rvalid", rvalid_o, 2'b00);
    chk("spur_result", result_o, 0);
    tick();
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("spur_clear", spurious_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
